// File: rtl/dvi_timing_gen.sv
// Video timing generator and pixel pacer: raster counters, SEEK/LOCKED frame
// alignment against a valid/ready RGB stream, registered DVI-side outputs.
module dvi_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        pixel_clk,
    input  logic        gpuclk_rst_b,
    input  logic        enable,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    input  logic        in_sof,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_b,
    output logic [7:0]  pixel_r,
    output logic [7:0]  pixel_g,
    output logic [7:0]  pixel_b,
    output logic        frame_start,
    output logic        underflow,
    output logic        misalign
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    typedef enum logic {SEEK, LOCKED} state_t;

    state_t          state_reg, state_next;
    logic [HW-1:0]   hcnt_reg, hcnt_next;
    logic [VW-1:0]   vcnt_reg, vcnt_next;
    logic            hsync_reg, vsync_reg, blank_b_reg, frame_start_reg;
    logic            underflow_reg, misalign_reg;
    logic [23:0]     pixel_reg;

    logic act, at_origin, hs_on, vs_on, sof_early;
    logic accept_pix, uf_set, mis_set;

    assign act       = (hcnt_reg < H_ACT_C) && (vcnt_reg < V_ACT_C);
    assign at_origin = (hcnt_reg == '0) && (vcnt_reg == '0);
    assign hs_on     = (hcnt_reg >= H_SYNC_S) && (hcnt_reg < H_SYNC_E);
    assign vs_on     = (vcnt_reg >= V_SYNC_S) && (vcnt_reg < V_SYNC_E);
    // An SOF anywhere but the origin is refused so it stays queued for the next frame.
    assign sof_early = in_valid && in_sof && !at_origin;

    always_comb begin
        hcnt_next = hcnt_reg;
        vcnt_next = vcnt_reg;
        if (!enable) begin
            hcnt_next = '0;
            vcnt_next = '0;
        end else if (hcnt_reg == H_LAST) begin
            hcnt_next = '0;
            vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
        end else begin
            hcnt_next = hcnt_reg + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        accept_pix = 1'b0;
        uf_set     = 1'b0;
        mis_set    = 1'b0;
        if (!enable) begin
            state_next = SEEK;
        end else begin
            case (state_reg)
                SEEK: begin
                    in_ready = in_valid && (!in_sof || at_origin);
                    if (in_valid && in_sof && at_origin) begin
                        state_next = LOCKED;
                        accept_pix = 1'b1;
                    end
                end
                LOCKED: begin
                    if (act) begin
                        in_ready = !sof_early;
                        if (!in_valid) begin
                            uf_set     = 1'b1;
                            state_next = SEEK;
                        end else if (sof_early) begin
                            mis_set    = 1'b1;
                            state_next = SEEK;
                        end else begin
                            accept_pix = 1'b1;
                        end
                    end
                end
                default: state_next = SEEK;
            endcase
        end
    end

    always_ff @(posedge pixel_clk or negedge gpuclk_rst_b) begin
        if (!gpuclk_rst_b) begin
            state_reg       <= SEEK;
            hcnt_reg        <= '0;
            vcnt_reg        <= '0;
            hsync_reg       <= ~HS_POL;
            vsync_reg       <= ~VS_POL;
            blank_b_reg     <= 1'b0;
            pixel_reg       <= '0;
            frame_start_reg <= 1'b0;
            underflow_reg   <= 1'b0;
            misalign_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hcnt_reg      <= hcnt_next;
            vcnt_reg      <= vcnt_next;
            underflow_reg <= underflow_reg | uf_set;
            misalign_reg  <= misalign_reg | mis_set;
            if (enable) begin
                hsync_reg       <= hs_on ? HS_POL : ~HS_POL;
                vsync_reg       <= vs_on ? VS_POL : ~VS_POL;
                blank_b_reg     <= act;
                pixel_reg       <= accept_pix ? in_data : '0;
                frame_start_reg <= at_origin;
            end else begin
                hsync_reg       <= ~HS_POL;
                vsync_reg       <= ~VS_POL;
                blank_b_reg     <= 1'b0;
                pixel_reg       <= '0;
                frame_start_reg <= 1'b0;
            end
        end
    end

    // Channel order in the word is {R, G, B}, so channel 0 is blue.
    logic [7:0] chan [3];
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign chan[gi] = pixel_reg[gi*8 +: 8];
        end
    endgenerate

    assign pixel_b     = chan[0];
    assign pixel_g     = chan[1];
    assign pixel_r     = chan[2];
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign blank_b     = blank_b_reg;
    assign frame_start = frame_start_reg;
    assign underflow   = underflow_reg;
    assign misalign    = misalign_reg;
endmodule

// File: doc/dvi_timing_gen.md
# dvi_timing_gen

Video timing generator and pixel pacer in the `pixel_clk` domain, directly upstream of the DVI output stage. Pulls 24-bit RGB pixels from a valid/ready stream and aligns each frame to its start-of-frame marker. Produces registered `hsync`, `vsync`, `blank_b` and `pixel_r/g/b` for the DVI encoder. Detects underflow and misalignment, then resynchronises on the next frame.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, hsync active level (0 = active-low)
- `VS_POL`, 0, vsync active level (0 = active-low)
- `pixel_clk` in 1 — pixel clock; the only clock
- `gpuclk_rst_b` in 1 — asynchronous, active-low reset
- `enable` in 1 — run timing; 0 = hold idle
- `in_valid` in 1 — upstream pixel valid
- `in_ready` out 1 — pixel accepted when `in_valid && in_ready`
- `in_data` in 24 — {R[23:16], G[15:8], B[7:0]}
- `in_sof` in 1 — marks the first pixel of a frame
- `hsync`, `vsync` out 1 — sync outputs, polarity set by parameter
- `blank_b` out 1 — 1 during active video (drives DE)
- `pixel_r`, `pixel_g`, `pixel_b` out 8 — pixel data; 0 when `blank_b` = 0
- `frame_start` out 1 — 1-cycle pulse coincident with output pixel (0,0)
- `underflow` out 1 — sticky; active pixel had no valid input
- `misalign` out 1 — sticky; `in_sof` seen at a position other than (0,0)

## Operation
- Counters:
  - `hcnt` runs 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters.
  - `vcnt` runs 0..V_TOTAL-1. It increments when `hcnt` wraps and wraps to 0 after V_TOTAL-1.
- Regions, in order: active (cnt < ACTIVE), front porch, sync, back porch.
  - hsync is active when H_ACTIVE+H_FP ≤ `hcnt` < H_ACTIVE+H_FP+H_SYNC.
  - vsync uses the same rule on `vcnt` with the V_* parameters.
- `act` = (`hcnt` < H_ACTIVE) && (`vcnt` < V_ACTIVE).
- State machine, SEEK/LOCKED; reset state is SEEK.
  - SEEK:
    - `in_ready` = `in_valid && !in_sof`. Non-SOF pixels are discarded continuously.
    - A pixel with `in_sof`=1 is held (`in_ready`=0) until `hcnt`=0 and `vcnt`=0. That pixel is then consumed and the state moves to LOCKED.
    - Active pixels output while in SEEK are black, with `blank_b`=1.
  - LOCKED:
    - `in_ready` = `act`.
    - If `act && !in_valid`: output black, set `underflow`, go to SEEK.
    - If an accepted pixel has `in_sof`=1 and position ≠ (0,0): set `misalign`, output black, go to SEEK. The offending pixel is not consumed.
  - Outside active video, `in_ready`=0 in LOCKED.
- `enable`=0:
  - Synchronously clears counters and forces state to SEEK.
  - Forces `in_ready`=0, `blank_b`=0, syncs inactive and pixels 0.
  - Sticky flags hold their value.
- Sticky flags clear only on reset.

## Timing
- All outputs are registered. Values computed from (`hcnt`, `vcnt`) in cycle N appear in cycle N+1.
- Pixel accepted in cycle N appears on `pixel_*` in cycle N+1, with `blank_b`=1.
- Reset values:
  - counters 0, state SEEK
  - `hsync` = ~HS_POL, `vsync` = ~VS_POL
  - `blank_b`=0, pixels 0, `in_ready`=0
  - `frame_start`=0, `underflow`=0, `misalign`=0
- Reset assertion mid-frame forces reset values immediately (asynchronously). Release is synchronous to the next `pixel_clk` edge; counting starts from (0,0).
- `in_ready` is combinational from state, counters and `in_valid`/`in_sof`. Upstream must not depend combinationally on `in_ready`.
- After `enable` rises, the first output edge shows position (0,0).
- Simultaneous events:
  - If underflow and the `vcnt` wrap fall in the same cycle, underflow takes priority.
  - The next frame start may relock in the same frame wrap if an SOF pixel is waiting.

## Test plan
Bench parameters: H=8/2/3/2 (H_TOTAL 15), V=4/1/2/1 (V_TOTAL 8), 120 cycles/frame, `HS_POL`=`VS_POL`=0.

- Reset, then `enable`=1 with no input:
  - `hsync` low for exactly 3 cycles every 15.
  - `vsync` low for 30 cycles per 120.
  - `blank_b` high for 8 cycles on each of 4 lines.
  - Pixels 0, no flags set.
- Continuous stream of 32 pixels per frame, first with `in_sof`, data = index:
  - Locks on the first frame.
  - `frame_start` pulses with pixel 0.
  - Output order 0..31 in the active window, no flags.
- Drop `in_valid` for 1 cycle at pixel 13 of a locked frame:
  - `underflow`=1; pixels from 13 onward are black.
  - Relocks at the next frame, and the SOF pixel appears at (0,0).
- Send an SOF pixel at position 5 while locked:
  - `misalign`=1; the rest of the frame is black.
  - The held SOF pixel is output at the next frame's (0,0).
- Feed 10 junk pixels before SOF while in SEEK:
  - All junk is consumed with `in_ready`=1.
  - The SOF pixel is held until (0,0).
- Assert `gpuclk_rst_b` low mid-line, then `enable`=0 mid-frame:
  - All outputs take reset/idle values at once.
  - Sticky flags survive `enable`=0 but not reset.
